// File: rtl/cdr_pkg.sv
// Shared types and period defaults for the CDR loop controller and the phase detector.
package cdr_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StAcq    = 2'd1,
        StTrack  = 2'd2,
        StLocked = 2'd3
    } cdr_state_e;

    typedef logic [5:0] nb_t;

    localparam int unsigned NbDefault = 25;
    localparam int unsigned NbMin     = 20;
    localparam int unsigned NbMax     = 30;

endpackage

// File: rtl/cdr_vote_acc.sv
// Saturating early/late vote accumulator with threshold compare and clear.
module cdr_vote_acc #(
    parameter int unsigned VOTE_TH = 8
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    input  logic valid_i,
    input  logic t_i,
    input  logic e_i,
    input  logic locked_i,
    output logic step_up_o,
    output logic step_dn_o
);

    localparam logic signed [6:0] ThLo = 7'(VOTE_TH);
    localparam logic signed [6:0] ThHi = 7'(2 * VOTE_TH);

    logic signed [5:0] acc_q, acc_d;
    logic signed [6:0] sum, sat, thr;

    always_comb begin
        sum = {acc_q[5], acc_q};
        if (t_i) begin
            sum = e_i ? sum + 7'sd1 : sum - 7'sd1;
        end
        if (sum > 7'sd31) begin
            sat = 7'sd31;
        end else if (sum < -7'sd31) begin
            sat = -7'sd31;
        end else begin
            sat = sum;
        end
        thr       = locked_i ? ThHi : ThLo;
        step_up_o = valid_i && (sat >= thr);
        step_dn_o = valid_i && (sat <= -thr);
    end

    // A crossing clears the accumulator even when the period is pinned at a limit.
    always_comb begin
        acc_d = acc_q;
        if (clr_i || step_up_o || step_dn_o) begin
            acc_d = '0;
        end else if (valid_i) begin
            acc_d = sat[5:0];
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/cdr_loop_ctrl.sv
// CDR loop controller: steps the phase-detector period from votes and tracks lock per window.
module cdr_loop_ctrl
    import cdr_pkg::*;
#(
    parameter int unsigned NB_DEFAULT = NbDefault,
    parameter int unsigned NB_MIN     = NbMin,
    parameter int unsigned NB_MAX     = NbMax,
    parameter int unsigned VOTE_TH    = 8,
    parameter int unsigned WIN_LEN    = 32,
    parameter int unsigned LOCK_WIN   = 4
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_en,
    input  logic       i_valid,
    input  logic       i_T,
    input  logic       i_E,
    output nb_t        o_nb_P,
    output logic       o_adj,
    output logic       o_dir,
    output logic       o_lock,
    output logic [1:0] o_state
);

    localparam int unsigned WinW = $clog2(WIN_LEN);
    localparam int unsigned QW   = $clog2(LOCK_WIN + 1);
    localparam logic [WinW-1:0] WinLast   = WinW'(WIN_LEN - 1);
    localparam logic [QW-1:0]   QuietLock = QW'(LOCK_WIN);
    localparam nb_t NbDef = nb_t'(NB_DEFAULT);
    localparam nb_t NbLo  = nb_t'(NB_MIN);
    localparam nb_t NbHi  = nb_t'(NB_MAX);

    cdr_state_e      state_q, state_d;
    nb_t             nb_q, nb_d;
    logic            adj_q, adj_d, dir_q, dir_d;
    logic [WinW-1:0] win_q, win_d;
    logic [1:0]      nadj_q, nadj_d, nadj_win;
    logic            tseen_q, tseen_d;
    logic [QW-1:0]   quiet_q, quiet_d;
    logic            vote_valid, step_up, step_dn, inc_ok, dec_ok, adj_ev;
    logic            win_end, t_win, reload, acc_clr;

    assign vote_valid = i_valid && i_en && (state_q != StIdle);
    assign win_end    = vote_valid && (win_q == WinLast);
    assign t_win      = tseen_q || (vote_valid && i_T);
    assign inc_ok     = step_up && (nb_q < NbHi);
    assign dec_ok     = step_dn && (nb_q > NbLo);
    assign adj_ev     = inc_ok || dec_ok;
    assign nadj_win   = (adj_ev && nadj_q != 2'd3) ? nadj_q + 2'd1 : nadj_q;

    cdr_vote_acc #(
        .VOTE_TH (VOTE_TH)
    ) u_vote_acc (
        .clk_i     (i_clk),
        .rst_ni    (i_rst),
        .clr_i     (acc_clr),
        .valid_i   (vote_valid),
        .t_i       (i_T),
        .e_i       (i_E),
        .locked_i  (state_q == StLocked),
        .step_up_o (step_up),
        .step_dn_o (step_dn)
    );

    always_comb begin
        state_d = state_q;
        quiet_d = quiet_q;
        unique case (state_q)
            StIdle: begin
                state_d = StAcq;
                quiet_d = '0;
            end
            StAcq: begin
                if (win_end && t_win && nadj_win == 2'd0) begin
                    state_d = StTrack;
                    quiet_d = QW'(1);
                end
            end
            StTrack: begin
                if (win_end) begin
                    if (nadj_win != 2'd0 || !t_win) begin
                        quiet_d = '0;
                    end else begin
                        quiet_d = quiet_q + QW'(1);
                        if (quiet_d >= QuietLock) begin
                            state_d = StLocked;
                        end
                    end
                end
            end
            StLocked: begin
                if (win_end && (nadj_win[1] || !t_win)) begin
                    state_d = StAcq;
                end
            end
            default: state_d = StIdle;
        endcase
        if (!i_en) begin
            state_d = StIdle;
            quiet_d = '0;
        end
    end

    // A reload on disable or lock loss supersedes a step sampled in the same cycle.
    always_comb begin
        reload  = (state_d == StIdle) || (state_q == StLocked && state_d == StAcq);
        acc_clr = reload || (state_q == StIdle);
        nb_d    = nb_q;
        adj_d   = 1'b0;
        dir_d   = dir_q;
        if (reload) begin
            nb_d = NbDef;
        end else if (inc_ok) begin
            nb_d  = nb_q + 6'd1;
            adj_d = 1'b1;
            dir_d = 1'b1;
        end else if (dec_ok) begin
            nb_d  = nb_q - 6'd1;
            adj_d = 1'b1;
            dir_d = 1'b0;
        end
        win_d   = win_q;
        nadj_d  = nadj_q;
        tseen_d = tseen_q;
        if (state_d != state_q || win_end) begin
            win_d   = '0;
            nadj_d  = '0;
            tseen_d = 1'b0;
        end else if (vote_valid) begin
            win_d   = win_q + WinW'(1);
            nadj_d  = nadj_win;
            tseen_d = t_win;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            state_q <= StIdle;
            nb_q    <= NbDef;
            adj_q   <= 1'b0;
            dir_q   <= 1'b0;
            win_q   <= '0;
            nadj_q  <= '0;
            tseen_q <= 1'b0;
            quiet_q <= '0;
        end else begin
            state_q <= state_d;
            nb_q    <= nb_d;
            adj_q   <= adj_d;
            dir_q   <= dir_d;
            win_q   <= win_d;
            nadj_q  <= nadj_d;
            tseen_q <= tseen_d;
            quiet_q <= quiet_d;
        end
    end

    assign o_nb_P  = nb_q;
    assign o_adj   = adj_q;
    assign o_dir   = dir_q;
    assign o_lock  = (state_q == StLocked);
    assign o_state = state_q;

endmodule

// File: tb/tb_cdr_loop_ctrl.sv
// Bench for cdr_loop_ctrl: strobe-level reference model checked every cycle plus directed literals.
module tb_cdr_loop_ctrl;

    localparam int NbDef = 25;
    localparam int NbLo  = 20;
    localparam int NbHi  = 30;
    localparam int Th    = 8;
    localparam int Win   = 32;
    localparam int LockW = 4;

    typedef struct {
        int st;
        int nb;
        int acc;
        int wcnt;
        int nadj;
        int tany;
        int quiet;
        bit adj;
        bit dir;
    } mdl_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic       valid = 1'b0;
    logic       t = 1'b0;
    logic       e = 1'b0;
    logic [5:0] nb;
    logic       adj, dir, lock;
    logic [1:0] st;

    mdl_t m;
    int   n_cmp = 0;
    int   n_fail = 0;
    int   adj_seen = 0;
    int   a0;
    bit   chk_en = 1'b0;

    cdr_loop_ctrl dut (
        .i_clk   (clk),
        .i_rst   (rst_n),
        .i_en    (en),
        .i_valid (valid),
        .i_T     (t),
        .i_E     (e),
        .o_nb_P  (nb),
        .o_adj   (adj),
        .o_dir   (dir),
        .o_lock  (lock),
        .o_state (st)
    );

    always #10 clk = ~clk;

    // Model thinks in strobes: count to 32, judge the window, apply step or reload.
    function automatic mdl_t mdl_next(mdl_t c, bit r, bit en_i, bit v, bit ti, bit ei);
        mdl_t n;
        int   th, step, nbn;
        bit   chg;
        n = c;
        n.adj = 1'b0;
        if (!r || !en_i) begin
            n.st = 0; n.nb = NbDef; n.acc = 0; n.wcnt = 0; n.nadj = 0; n.tany = 0; n.quiet = 0;
            if (!r) n.dir = 1'b0;
            return n;
        end
        if (c.st == 0) begin
            n.st = 1;
            return n;
        end
        if (!v) return n;
        if (ti) n.acc += ei ? 1 : -1;
        if (n.acc > 31) n.acc = 31;
        if (n.acc < -31) n.acc = -31;
        th = (c.st == 3) ? 2 * Th : Th;
        step = 0;
        if (n.acc >= th) step = 1;
        else if (n.acc <= -th) step = -1;
        if (step != 0) n.acc = 0;
        nbn = c.nb + step;
        chg = (step != 0) && nbn >= NbLo && nbn <= NbHi;
        if (chg && n.nadj < 3) n.nadj++;
        if (ti) n.tany = 1;
        n.wcnt++;
        if (n.wcnt == Win) begin
            case (c.st)
                1: if (n.tany != 0 && n.nadj == 0) begin n.st = 2; n.quiet = 1; end
                2: begin
                    if (n.nadj > 0 || n.tany == 0) n.quiet = 0;
                    else begin
                        n.quiet++;
                        if (n.quiet >= LockW) n.st = 3;
                    end
                end
                3: if (n.nadj >= 2 || n.tany == 0) n.st = 1;
                default: ;
            endcase
            n.wcnt = 0; n.nadj = 0; n.tany = 0;
        end
        if (c.st == 3 && n.st == 1) begin
            n.nb = NbDef;
            n.acc = 0;
        end else if (chg) begin
            n.nb = nbn;
            n.adj = 1'b1;
            n.dir = (step > 0);
        end
        return n;
    endfunction

    always @(posedge clk) m <= mdl_next(m, rst_n, en, valid, t, e);

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", nm, got, want, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("nb", 32'(nb), m.nb);
            check("adj", 32'(adj), 32'(m.adj));
            check("dir", 32'(dir), 32'(m.dir));
            check("lock", 32'(lock), (m.st == 3) ? 1 : 0);
            check("state", 32'(st), m.st);
            if (adj === 1'b1) adj_seen++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe(input bit tt, input bit ee);
        valid = 1'b1; t = tt; e = ee;
        tick();
        valid = 1'b0;
        tick();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        valid = 1'b1; t = 1'b1; e = 1'b1;
        tick();
        tick();
        valid = 1'b0;
        rst_n = 1'b1;
        en = 1'b1;
        tick();
    endtask

    task automatic alt_windows(input int nw);
        for (int w = 0; w < nw; w++) begin
            for (int i = 0; i < Win; i++) strobe(1'b1, (i % 2) == 0);
        end
    endtask

    initial begin
        tick();
        chk_en = 1'b1;
        check("rst_state", 32'(st), 0);
        check("rst_nb", 32'(nb), 25);
        check("rst_adj", 32'(adj), 0);
        check("rst_dir", 32'(dir), 0);
        check("rst_lock", 32'(lock), 0);
        tick();
        rst_n = 1'b1;
        en = 1'b1;
        tick();
        check("idle_to_acq", 32'(st), 1);

        // 32 early votes: steps at strobes 8,16,24,32
        for (int i = 1; i <= 32; i++) begin
            strobe(1'b1, 1'b1);
            if (i == 8) check("acq_nb_at8", 32'(nb), 26);
        end
        check("acq_pulses", adj_seen, 4);
        check("acq_nb", 32'(nb), 29);
        check("acq_dir", 32'(dir), 1);
        check("acq_state", 32'(st), 1);

        // Upper limit: hold at 30, no pulse, accumulator left at zero
        for (int i = 0; i < 8; i++) strobe(1'b1, 1'b1);
        check("max_nb", 32'(nb), 30);
        for (int i = 0; i < 8; i++) strobe(1'b1, 1'b1);
        check("max_hold_nb", 32'(nb), 30);
        check("max_hold_pulses", adj_seen, 5);
        for (int i = 0; i < 7; i++) strobe(1'b1, 1'b0);
        check("acc_zero_7", 32'(nb), 30);
        strobe(1'b1, 1'b0);
        check("acc_zero_8", 32'(nb), 29);
        check("dec_dir", 32'(dir), 0);

        // Quiet windows: ACQ -> TRACK -> LOCKED
        do_reset();
        alt_windows(1);
        check("trk_after_w1", 32'(st), 2);
        alt_windows(2);
        check("trk_after_w3", 32'(lock), 0);
        alt_windows(1);
        check("lock_after_w4", 32'(lock), 1);
        alt_windows(1);
        check("lock_w5_lock", 32'(lock), 1);
        check("lock_w5_nb", 32'(nb), 25);

        // Lock loss: two late steps in one LOCKED window
        a0 = adj_seen;
        for (int i = 1; i <= 32; i++) begin
            strobe(1'b1, 1'b0);
            if (i == 16) check("lck_nb_at16", 32'(nb), 24);
        end
        check("loss_state", 32'(st), 1);
        check("loss_lock", 32'(lock), 0);
        check("loss_nb", 32'(nb), 25);
        check("loss_pulses", adj_seen - a0, 1);

        // Disable and mid-window reset
        do_reset();
        alt_windows(4);
        check("relock", 32'(lock), 1);
        en = 1'b0;
        tick();
        check("dis_state", 32'(st), 0);
        check("dis_nb", 32'(nb), 25);
        en = 1'b1;
        tick();
        check("reen_state", 32'(st), 1);
        for (int i = 0; i < 10; i++) strobe(1'b1, 1'b1);
        check("pre_rst_nb", 32'(nb), 26);
        rst_n = 1'b0;
        valid = 1'b1; t = 1'b1; e = 1'b1;
        tick();
        valid = 1'b0;
        check("mid_rst_state", 32'(st), 0);
        check("mid_rst_nb", 32'(nb), 25);
        check("mid_rst_dir", 32'(dir), 0);
        check("mid_rst_lock", 32'(lock), 0);
        rst_n = 1'b1;
        tick();
        check("post_rst_adj", 32'(adj), 0);
        tick();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
